layer_sequencer: RTL and testbench



---
 rtl/layer_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Control FSM for a time-multiplexed fully-connected layer: walks neuron groups,
// streams input/weight reads and emits latency-aligned accumulator strobes.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | clear lane accumulators, issue element 0 of the group
// FETCH  | issue one element per cycle unless hold is high
// DRAIN  | wait MEM_LATENCY cycles for the last read data to accumulate
// BIAS   | add bias for the current group
// WRITE  | write lane results, advance to next group or finish
// DONE   | one-cycle completion pulse
module layer_sequencer #(
   parameter int INPUT_SIZE  = 784,
   parameter int NUM_NEURON  = 30,
   parameter int LANES       = 10,
   parameter int MEM_LATENCY = 1,
   localparam int GROUPS = NUM_NEURON / LANES,
   localparam int IAW    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
   localparam int WAW    = (INPUT_SIZE * GROUPS > 1) ? $clog2(INPUT_SIZE * GROUPS) : 1,
   localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           hold,
   output logic           busy,
   output logic           done,
   output logic           rd_en,
   output logic [IAW-1:0] in_addr,
   output logic [WAW-1:0] w_addr,
   output logic           acc_clear,
   output logic           acc_en,
   output logic           bias_en,
   output logic [GW-1:0]  bias_addr,
   output logic           out_we,
   output logic [GW-1:0]  out_group
);

   localparam int KW = $clog2(INPUT_SIZE + 1);
   localparam int DW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_BIAS  = 3'd4;
   localparam logic [2:0] S_WRITE = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   logic [GW-1:0]          g_q, g_d;
   logic [WAW-1:0]         w_ptr_q, w_ptr_d;
   logic [DW-1:0]          drain_q, drain_d;
   logic                   issue;

   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   rd_en_q, rd_en_d;
   logic [IAW-1:0]         in_addr_q, in_addr_d;
   logic [WAW-1:0]         w_addr_q, w_addr_d;
   logic                   acc_clear_q, acc_clear_d;
   logic [MEM_LATENCY-1:0] acc_pipe_q, acc_pipe_d;
   logic                   bias_en_q, bias_en_d;
   logic [GW-1:0]          bias_addr_q, bias_addr_d;
   logic                   out_we_q, out_we_d;
   logic [GW-1:0]          out_group_q, out_group_d;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      g_d     = g_q;
      w_ptr_d = w_ptr_q;
      drain_d = drain_q;
      issue   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               g_d     = '0;
               k_d     = '0;
               w_ptr_d = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_FETCH;
            issue   = 1'b1;
         end
         S_FETCH: begin
            // k_q == INPUT_SIZE means the last read is on the bus this cycle
            if (k_q == KW'(INPUT_SIZE)) begin
               state_d = S_DRAIN;
               drain_d = DW'(MEM_LATENCY - 1);
            end else if (!hold) begin
               issue = 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_BIAS;
            else               drain_d = drain_q - 1'b1;
         end
         S_BIAS: state_d = S_WRITE;
         S_WRITE: begin
            if (g_q == GW'(GROUPS - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CLEAR;
               g_d     = g_q + 1'b1;
               k_d     = '0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // running weight pointer equals g*INPUT_SIZE + k without a multiplier
      if (issue) begin
         k_d     = k_q + 1'b1;
         w_ptr_d = w_ptr_q + 1'b1;
      end

      rd_en_d     = issue;
      in_addr_d   = issue ? k_q[IAW-1:0] : in_addr_q;
      w_addr_d    = issue ? w_ptr_q : w_addr_q;
      acc_clear_d = (state_d == S_CLEAR);
      bias_en_d   = (state_d == S_BIAS);
      bias_addr_d = (state_d == S_BIAS) ? g_q : bias_addr_q;
      out_we_d    = (state_d == S_WRITE);
      out_group_d = (state_d == S_WRITE) ? g_q : out_group_q;
      done_d      = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);

      acc_pipe_d[0] = rd_en_q;
      for (int i = 1; i < MEM_LATENCY; i++) acc_pipe_d[i] = acc_pipe_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         g_q         <= '0;
         w_ptr_q     <= '0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         in_addr_q   <= '0;
         w_addr_q    <= '0;
         acc_clear_q <= 1'b0;
         acc_pipe_q  <= '0;
         bias_en_q   <= 1'b0;
         bias_addr_q <= '0;
         out_we_q    <= 1'b0;
         out_group_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         g_q         <= g_d;
         w_ptr_q     <= w_ptr_d;
         drain_q     <= drain_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         in_addr_q   <= in_addr_d;
         w_addr_q    <= w_addr_d;
         acc_clear_q <= acc_clear_d;
         acc_pipe_q  <= acc_pipe_d;
         bias_en_q   <= bias_en_d;
         bias_addr_q <= bias_addr_d;
         out_we_q    <= out_we_d;
         out_group_q <= out_group_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign in_addr   = in_addr_q;
   assign w_addr    = w_addr_q;
   assign acc_clear = acc_clear_q;
   assign acc_en    = acc_pipe_q[MEM_LATENCY-1];
   assign bias_en   = bias_en_q;
   assign bias_addr = bias_addr_q;
   assign out_we    = out_we_q;
   assign out_group = out_group_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: INPUT_SIZE=4, NUM_NEURON=4, LANES=2,
// main instance MEM_LATENCY=2, second instance MEM_LATENCY=1.
module tb_layer_sequencer;

   typedef struct packed {
      logic [31:0] cyc;
      logic        dut;
      logic        rd;
      logic [1:0]  ina;
      logic [2:0]  wa;
      logic        clr;
      logic        acc;
      logic        bias;
      logic        ba;
      logic        we;
      logic        og;
      logic        dn;
      logic        bsy;
   } rec_t;

   logic clk = 1'b0;
   logic reset, start, hold, start2, hold2;
   always #5 clk = ~clk;

   logic       busy1, done1, rd1, clr1, acc1, bias1, ba1, we1, og1;
   logic [1:0] in1;
   logic [2:0] w1;
   logic       busy2, done2, rd2, clr2, acc2, bias2, ba2, we2, og2;
   logic [1:0] in2;
   logic [2:0] w2;

   layer_sequencer #(.INPUT_SIZE(4), .NUM_NEURON(4), .LANES(2), .MEM_LATENCY(2)) u_dut (
      .clk(clk), .reset(reset), .start(start), .hold(hold),
      .busy(busy1), .done(done1), .rd_en(rd1), .in_addr(in1), .w_addr(w1),
      .acc_clear(clr1), .acc_en(acc1), .bias_en(bias1), .bias_addr(ba1),
      .out_we(we1), .out_group(og1));

   layer_sequencer #(.INPUT_SIZE(4), .NUM_NEURON(4), .LANES(2), .MEM_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset), .start(start2), .hold(hold2),
      .busy(busy2), .done(done2), .rd_en(rd2), .in_addr(in2), .w_addr(w2),
      .acc_clear(clr2), .acc_en(acc2), .bias_en(bias2), .bias_addr(ba2),
      .out_we(we2), .out_group(og2));

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rec_t exp_q[$];
   rec_t snap_q[$];
   bit   end_req = 1'b0;

   // held address values as seen by each instance
   logic [1:0] m_in [2];
   logic [2:0] m_w  [2];
   logic       m_ba [2];
   logic       m_og [2];

   function automatic rec_t mk(input int c, input logic d, input logic rd, input logic [1:0] ina,
                               input logic [2:0] wa, input logic clr, input logic acc,
                               input logic bias, input logic ba, input logic we, input logic og,
                               input logic dn, input logic bsy);
      rec_t r;
      r.cyc = c; r.dut = d; r.rd = rd; r.ina = ina; r.wa = wa; r.clr = clr; r.acc = acc;
      r.bias = bias; r.ba = ba; r.we = we; r.og = og; r.dn = dn; r.bsy = bsy;
      return r;
   endfunction

   // Expected timeline of one layer run, relative to c0 (cycle in which start is sampled).
   task automatic push_run(input int which, input int c0, input int lat, input int hold_k,
                           input int hold_len, input int limit, output int done_c);
      logic       e_rd[64], e_clr[64], e_acc[64], e_bias[64], e_we[64], e_dn[64], e_g[64];
      logic [1:0] e_in[64];
      logic [2:0] e_w[64];
      int t;
      for (int i = 0; i < 64; i++) begin
         e_rd[i] = 0; e_clr[i] = 0; e_acc[i] = 0; e_bias[i] = 0; e_we[i] = 0;
         e_dn[i] = 0; e_g[i] = 0; e_in[i] = 0; e_w[i] = 0;
      end
      t = 1;
      for (int g = 0; g < 2; g++) begin
         e_clr[t] = 1; t++;
         for (int kk = 0; kk < 4; kk++) begin
            if (g == 0 && kk == hold_k) t += hold_len;
            e_rd[t] = 1; e_in[t] = 2'(kk); e_w[t] = 3'(g * 4 + kk); t++;
         end
         t += lat;
         e_bias[t] = 1; e_g[t] = 1'(g); t++;
         e_we[t] = 1; e_g[t] = 1'(g); t++;
      end
      e_dn[t] = 1;
      done_c = c0 + t;
      for (int c = lat; c <= t; c++) e_acc[c] = e_rd[c - lat];
      for (int c = 1; c <= t && c <= limit; c++) begin
         if (e_rd[c]) begin m_in[which] = e_in[c]; m_w[which] = e_w[c]; end
         if (e_bias[c]) m_ba[which] = e_g[c];
         if (e_we[c]) m_og[which] = e_g[c];
         if (e_rd[c] | e_clr[c] | e_acc[c] | e_bias[c] | e_we[c] | e_dn[c])
            exp_q.push_back(mk(c0 + c, 1'(which), e_rd[c], m_in[which], m_w[which], e_clr[c],
                               e_acc[c], e_bias[c], m_ba[which], e_we[c], m_og[which],
                               e_dn[c], 1'b1));
      end
   endtask

   task automatic push_idle_snap(input int c);
      snap_q.push_back(mk(c, 1'b0, 1'b0, m_in[0], m_w[0], 1'b0, 1'b0, 1'b0, m_ba[0], 1'b0,
                          m_og[0], 1'b0, 1'b0));
   endtask

   task automatic zero_model();
      for (int i = 0; i < 2; i++) begin m_in[i] = 0; m_w[i] = 0; m_ba[i] = 0; m_og[i] = 0; end
   endtask

   task automatic step_to(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   // ---------------- monitor / checker ----------------
   int   checks = 0, failures = 0;
   int   n_rd = 0, n_acc = 0, n_we = 0, w_max = 0;
   rec_t obs[2];
   bit   act[2];

   always @(negedge clk) begin
      obs[0] = mk(cyc, 1'b0, rd1, in1, w1, clr1, acc1, bias1, ba1, we1, og1, done1, busy1);
      obs[1] = mk(cyc, 1'b1, rd2, in2, w2, clr2, acc2, bias2, ba2, we2, og2, done2, busy2);
      act[0] = (rd1 === 1'b1) || (clr1 === 1'b1) || (acc1 === 1'b1) || (bias1 === 1'b1) ||
               (we1 === 1'b1) || (done1 === 1'b1);
      act[1] = (rd2 === 1'b1) || (clr2 === 1'b1) || (acc2 === 1'b1) || (bias2 === 1'b1) ||
               (we2 === 1'b1) || (done2 === 1'b1);

      while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
         checks++; failures++;
         $display("FAIL missing_event at cyc=%0d: got nothing, required %p", cyc, exp_q[0]);
         void'(exp_q.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
         if (act[i]) begin
            checks++;
            if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc && exp_q[0].dut == 1'(i)) begin
               if (obs[i] !== exp_q[0]) begin
                  failures++;
                  $display("FAIL event dut%0d cyc=%0d: got %p required %p", i, cyc, obs[i], exp_q[0]);
               end
               void'(exp_q.pop_front());
            end else begin
               failures++;
               $display("FAIL unexpected_event dut%0d cyc=%0d: got %p required no strobe", i, cyc, obs[i]);
            end
         end
      end

      while (snap_q.size() > 0 && int'(snap_q[0].cyc) < cyc) begin
         checks++; failures++;
         $display("FAIL stale_snapshot cyc=%0d: required %p", cyc, snap_q[0]);
         void'(snap_q.pop_front());
      end
      if (snap_q.size() > 0 && int'(snap_q[0].cyc) == cyc) begin
         checks++;
         if (obs[0] !== snap_q[0]) begin
            failures++;
            $display("FAIL idle_snapshot cyc=%0d: got %p required %p", cyc, obs[0], snap_q[0]);
         end
         void'(snap_q.pop_front());
      end

      if (rd1 === 1'b1) begin
         n_rd++;
         if (int'(w1) > w_max) w_max = int'(w1);
      end
      if (acc1 === 1'b1) n_acc++;
      if (we1 === 1'b1) n_we++;
      if (done1 === 1'b1) begin
         checks += 4;
         if (n_rd != 8)  begin failures++; $display("FAIL run_rd_count got %0d required 8", n_rd); end
         if (n_acc != 8) begin failures++; $display("FAIL run_acc_count got %0d required 8", n_acc); end
         if (n_we != 2)  begin failures++; $display("FAIL run_we_count got %0d required 2", n_we); end
         if (w_max > 7)  begin failures++; $display("FAIL run_w_addr_max got %0d required <=7", w_max); end
         n_rd = 0; n_acc = 0; n_we = 0; w_max = 0;
      end
      if (reset === 1'b1) begin n_rd = 0; n_acc = 0; n_we = 0; w_max = 0; end

      if (end_req) begin
         checks++;
         if (exp_q.size() != 0 || snap_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got %0d events %0d snapshots required 0",
                     exp_q.size(), snap_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int c0, dc, x;
      reset = 1; start = 0; hold = 0; start2 = 0; hold2 = 0;
      zero_model();
      repeat (3) @(posedge clk);
      #1 reset = 0;
      push_idle_snap(cyc);

      // nominal run
      c0 = cyc;
      push_run(0, c0, 2, -1, 0, 1000, dc);
      start = 1; step_to(c0 + 1); start = 0;
      push_idle_snap(dc + 1);
      step_to(dc + 3);

      // two hold cycles while k=2 is pending
      c0 = cyc;
      push_run(0, c0, 2, 2, 2, 1000, dc);
      start = 1; step_to(c0 + 1); start = 0;
      step_to(c0 + 3); hold = 1;
      step_to(c0 + 5); hold = 0;
      push_idle_snap(dc + 1);
      step_to(dc + 3);

      // starts during a run are ignored; then two back-to-back runs
      c0 = cyc;
      push_run(0, c0, 2, -1, 0, 1000, dc);
      start = 1; step_to(c0 + 1); start = 0;
      step_to(c0 + 5);  start = 1; step_to(c0 + 6);  start = 0;
      step_to(c0 + 12); start = 1; step_to(c0 + 13); start = 0;
      step_to(dc + 1);
      for (int r = 0; r < 2; r++) begin
         c0 = cyc;
         push_run(0, c0, 2, -1, 0, 1000, dc);
         start = 1; step_to(c0 + 1); start = 0;
         step_to(dc + 1);
      end
      push_idle_snap(cyc);
      step_to(cyc + 3);

      // reset in the middle of group 0
      c0 = cyc;
      push_run(0, c0, 2, -1, 0, 6, dc);
      start = 1; step_to(c0 + 1); start = 0;
      step_to(c0 + 6); reset = 1;
      step_to(c0 + 7); reset = 0;
      zero_model();
      push_idle_snap(c0 + 7);
      step_to(c0 + 10);

      // nominal run after reset, with hold toggled outside FETCH
      c0 = cyc;
      push_run(0, c0, 2, -1, 0, 1000, dc);
      start = 1; step_to(c0 + 1); start = 0; hold = 1;
      step_to(c0 + 2);  hold = 0;
      step_to(c0 + 5);  hold = 1;
      step_to(c0 + 10); hold = 0;
      push_idle_snap(dc + 1);
      step_to(dc + 3);

      // start together with reset: reset wins
      x = cyc;
      start = 1; reset = 1;
      step_to(x + 1); start = 0; reset = 0;
      zero_model();
      push_idle_snap(x + 1);
      push_idle_snap(x + 2);
      step_to(x + 4);

      // MEM_LATENCY=1 instance
      c0 = cyc;
      push_run(1, c0, 1, -1, 0, 1000, dc);
      start2 = 1; step_to(c0 + 1); start2 = 0;
      step_to(dc + 3);

      end_req = 1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_finish got no summary required summary");
      $fatal(1, "monitor did not finish");
   end

endmodule
